md5_msg_feeder: RTL and testbench

Front-end block that turns a raw message word stream into MD5-padded 512-bit blocks. It drives the hash core's data and state-load inputs: sixteen 32-bit words per block, with the initial state loaded on the first block. It inserts the 0x80 pad byte, the zero fill and the 64-bit little-endian bit length. Between blocks it holds off until the core reports a digest.

---
 rtl/md5_msg_feeder.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_md5_msg_feeder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_msg_feeder.sv
// ---------------------------------------------------------------------------
// md5_msg_feeder
//
// Turns a raw 32-bit message word stream into MD5-padded 512-bit blocks for
// an MD5 hash core. Each block is presented as sixteen 32-bit words on
// dataOut/dataVld.
//
// On the first block, the initial chaining state is loaded through
// stateVld/state*Out. The block inserts:
//   - the 0x80 pad byte,
//   - the zero fill,
//   - the 64-bit little-endian bit length.
// Between blocks it waits for the core's digestVld.
//
// Optional feature macro: MD5_FEED_EXT_IV_EN
//   defined   : ivA..ivD inputs supply the initial state. They are sampled
//               when a message starts (IDLE->INIT).
//   undefined : the standard MD5 IV constants are used.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   msgVld     in   upstream word valid
//   msgData    in   message word, byte 0 in [7:0]
//   msgLast    in   final word of the message
//   msgBytes   in   valid bytes in the final word (0..4; >4 treated as 4)
//   msgRdy     out  word accepted on an edge where msgVld & msgRdy
//   digestVld  in   core finished processing the current block
//   ivA..ivD   in   external initial state (MD5_FEED_EXT_IV_EN only)
//   stateVld   out  state load strobe
//   stateA..DOut out initial state value
//   dataVld    out  block word valid
//   dataOut    out  block word
//   busy       out  message in progress
// ---------------------------------------------------------------------------
module md5_msg_feeder #(
  parameter int DATA_WIDTH   = 32,
  parameter int STATE_DWIDTH = 32,
  parameter int LEN_WIDTH    = 61
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    msgVld,
  input  logic [DATA_WIDTH-1:0]   msgData,
  input  logic                    msgLast,
  input  logic [2:0]              msgBytes,
  output logic                    msgRdy,
  input  logic                    digestVld,
`ifdef MD5_FEED_EXT_IV_EN
  input  logic [STATE_DWIDTH-1:0] ivA,
  input  logic [STATE_DWIDTH-1:0] ivB,
  input  logic [STATE_DWIDTH-1:0] ivC,
  input  logic [STATE_DWIDTH-1:0] ivD,
`endif
  output logic                    stateVld,
  output logic [STATE_DWIDTH-1:0] stateAOut,
  output logic [STATE_DWIDTH-1:0] stateBOut,
  output logic [STATE_DWIDTH-1:0] stateCOut,
  output logic [STATE_DWIDTH-1:0] stateDOut,
  output logic                    dataVld,
  output logic [DATA_WIDTH-1:0]   dataOut,
  output logic                    busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_DATA = 3'd2,
    ST_PAD  = 3'd3,
    ST_LEN  = 3'd4,
    ST_WAIT = 3'd5
  } state_e;

`ifdef MD5_FEED_EXT_IV_EN
  logic [STATE_DWIDTH-1:0] iv_a_s, iv_b_s, iv_c_s, iv_d_s;
  assign iv_a_s = ivA;
  assign iv_b_s = ivB;
  assign iv_c_s = ivC;
  assign iv_d_s = ivD;
`else
  logic [STATE_DWIDTH-1:0] iv_a_s, iv_b_s, iv_c_s, iv_d_s;
  assign iv_a_s = STATE_DWIDTH'(32'h67452301);
  assign iv_b_s = STATE_DWIDTH'(32'hEFCDAB89);
  assign iv_c_s = STATE_DWIDTH'(32'h98BADCFE);
  assign iv_d_s = STATE_DWIDTH'(32'h10325476);
`endif

  // Keep the n valid low bytes, put 0x80 right after them, zero the rest.
  function automatic logic [DATA_WIDTH-1:0] pad_word(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [2:0] n);
    logic [DATA_WIDTH-1:0] w;
    case (n)
      3'd0:    w = DATA_WIDTH'(32'h00000080);
      3'd1:    w = DATA_WIDTH'({16'h0000, 8'h80, d[7:0]});
      3'd2:    w = DATA_WIDTH'({8'h00, 8'h80, d[15:0]});
      3'd3:    w = DATA_WIDTH'({8'h80, d[23:0]});
      default: w = d;
    endcase
    return w;
  endfunction

  state_e                  state_q, state_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic [LEN_WIDTH-1:0]    byte_cnt_q, byte_cnt_d;
  logic                    pad_done_q, pad_done_d;
  logic                    msg_done_q, msg_done_d;  // final message word already accepted
  logic                    last_blk_q, last_blk_d;  // current block carries the length
  logic                    msg_rdy_q, msg_rdy_d;
  logic                    state_vld_q, state_vld_d;
  logic [STATE_DWIDTH-1:0] st_a_q, st_a_d, st_b_q, st_b_d, st_c_q, st_c_d, st_d_q, st_d_d;
  logic                    data_vld_q, data_vld_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    busy_q, busy_d;
  logic [2:0]              nbytes_s;
  logic [63:0]             bit_len_s;

  assign nbytes_s  = (msgBytes > 3'd4) ? 3'd4 : msgBytes;
  assign bit_len_s = 64'(byte_cnt_q) << 3;

  // Next-state and output decode for the block sequencer.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    byte_cnt_d  = byte_cnt_q;
    pad_done_d  = pad_done_q;
    msg_done_d  = msg_done_q;
    last_blk_d  = last_blk_q;
    st_a_d      = st_a_q;
    st_b_d      = st_b_q;
    st_c_d      = st_c_q;
    st_d_d      = st_d_q;
    data_vld_d  = 1'b0;
    data_d      = data_q;

    case (state_q)
      ST_IDLE: begin
        if (msgVld) begin
          state_d    = ST_INIT;
          wcnt_d     = 4'd0;
          byte_cnt_d = '0;
          pad_done_d = 1'b0;
          msg_done_d = 1'b0;
          last_blk_d = 1'b0;
          st_a_d     = iv_a_s;
          st_b_d     = iv_b_s;
          st_c_d     = iv_c_s;
          st_d_d     = iv_d_s;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_INIT: begin
        state_d = ST_DATA;
      end

      ST_DATA: begin
        if (msgVld) begin
          data_vld_d = 1'b1;
          wcnt_d     = wcnt_q + 4'd1;
          if (msgLast) begin
            msg_done_d = 1'b1;
            byte_cnt_d = byte_cnt_q + LEN_WIDTH'(nbytes_s);
            if (nbytes_s == 3'd4) begin
              // Full last word: the 0x80 byte goes into a PAD word.
              data_d     = msgData;
              pad_done_d = 1'b0;
              state_d    = (wcnt_q == 4'd15) ? ST_WAIT : ST_PAD;
            end else begin
              data_d     = pad_word(msgData, nbytes_s);
              pad_done_d = 1'b1;
              if (wcnt_q == 4'd15) begin
                state_d = ST_WAIT;
              end else if (wcnt_q == 4'd13) begin
                state_d = ST_LEN;
              end else begin
                // Index 14 also lands here: one zero word, then next block.
                state_d = ST_PAD;
              end
            end
          end else begin
            data_d     = msgData;
            byte_cnt_d = byte_cnt_q + LEN_WIDTH'(3'd4);
            state_d    = (wcnt_q == 4'd15) ? ST_WAIT : ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_PAD: begin
        data_vld_d = 1'b1;
        data_d     = pad_done_q ? '0 : DATA_WIDTH'(32'h00000080);
        pad_done_d = 1'b1;
        wcnt_d     = wcnt_q + 4'd1;
        if (wcnt_q == 4'd13) begin
          state_d = ST_LEN;
        end else if (wcnt_q == 4'd15) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_PAD;
        end
      end

      ST_LEN: begin
        data_vld_d = 1'b1;
        wcnt_d     = wcnt_q + 4'd1;
        if (wcnt_q == 4'd15) begin
          data_d     = DATA_WIDTH'(bit_len_s[63:32]);
          state_d    = ST_WAIT;
          last_blk_d = 1'b1;
        end else begin
          data_d  = DATA_WIDTH'(bit_len_s[31:0]);
          state_d = ST_LEN;
        end
      end

      ST_WAIT: begin
        if (digestVld) begin
          if (last_blk_q) begin
            state_d = ST_IDLE;
          end else begin
            wcnt_d  = 4'd0;
            state_d = msg_done_q ? ST_PAD : ST_DATA;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    msg_rdy_d   = (state_d == ST_DATA);
    state_vld_d = (state_d == ST_INIT);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= 4'd0;
      byte_cnt_q  <= '0;
      pad_done_q  <= 1'b0;
      msg_done_q  <= 1'b0;
      last_blk_q  <= 1'b0;
      msg_rdy_q   <= 1'b0;
      state_vld_q <= 1'b0;
      st_a_q      <= '0;
      st_b_q      <= '0;
      st_c_q      <= '0;
      st_d_q      <= '0;
      data_vld_q  <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      byte_cnt_q  <= byte_cnt_d;
      pad_done_q  <= pad_done_d;
      msg_done_q  <= msg_done_d;
      last_blk_q  <= last_blk_d;
      msg_rdy_q   <= msg_rdy_d;
      state_vld_q <= state_vld_d;
      st_a_q      <= st_a_d;
      st_b_q      <= st_b_d;
      st_c_q      <= st_c_d;
      st_d_q      <= st_d_d;
      data_vld_q  <= data_vld_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
    end
  end

  assign msgRdy    = msg_rdy_q;
  assign stateVld  = state_vld_q;
  assign stateAOut = st_a_q;
  assign stateBOut = st_b_q;
  assign stateCOut = st_c_q;
  assign stateDOut = st_d_q;
  assign dataVld   = data_vld_q;
  assign dataOut   = data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_md5_msg_feeder.sv
// ---------------------------------------------------------------------------
// tb_md5_msg_feeder
//
// Self-checking bench for md5_msg_feeder.
//
// Stimulus is random message words, with random valid gaps. An emulated core
// answers each completed block with digestVld after a random delay.
// Expected block words come from standard MD5 padding of the message byte
// string:
//   - append 0x80,
//   - zero fill until the length is 56 mod 64,
//   - append the 64-bit little-endian bit length,
//   - read the result back as little-endian 32-bit words.
// ---------------------------------------------------------------------------
module tb_md5_msg_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        msgVld;
  logic [31:0] msgData;
  logic        msgLast;
  logic [2:0]  msgBytes;
  logic        msgRdy;
  logic        digestVld;
  logic        stateVld;
  logic [31:0] stateAOut, stateBOut, stateCOut, stateDOut;
  logic        dataVld;
  logic [31:0] dataOut;
  logic        busy;

  logic [31:0] iv_exp [4];

`ifdef MD5_FEED_EXT_IV_EN
  logic [31:0] iv_a, iv_b, iv_c, iv_d;
`endif

  md5_msg_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msgVld    (msgVld),
    .msgData   (msgData),
    .msgLast   (msgLast),
    .msgBytes  (msgBytes),
    .msgRdy    (msgRdy),
    .digestVld (digestVld),
`ifdef MD5_FEED_EXT_IV_EN
    .ivA       (iv_a),
    .ivB       (iv_b),
    .ivC       (iv_c),
    .ivD       (iv_d),
`endif
    .stateVld  (stateVld),
    .stateAOut (stateAOut),
    .stateBOut (stateBOut),
    .stateCOut (stateCOut),
    .stateDOut (stateDOut),
    .dataVld   (dataVld),
    .dataOut   (dataOut),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] got_q [$];
  int          sv_cnt   = 0;
  int          ovl_cnt  = 0;
  logic [31:0] sv_a, sv_b, sv_c, sv_d;
  bit          stray_en = 1'b0;
  int          msg_id   = 0;
  int          last_base;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output monitor and emulated hash core (digest responder).
  initial begin
    int blk;
    int dly;
    blk = 0;
    dly = -1;
    digestVld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        blk = 0;
        dly = -1;
        digestVld = 1'b0;
      end else begin
        digestVld = 1'b0;
        if (dly == 0) begin
          digestVld = 1'b1;
          dly = -1;
        end else if (dly > 0) begin
          dly--;
        end
        if (dataVld) begin
          got_q.push_back(dataOut);
          blk++;
          if (blk == 16) begin
            blk = 0;
            dly = $urandom_range(0, 4);
          end else if (stray_en && ($urandom_range(0, 2) == 0)) begin
            digestVld = 1'b1;  // mid-block: the feeder must ignore it
          end
        end
        if (stateVld) begin
          sv_cnt++;
          sv_a = stateAOut;
          sv_b = stateBOut;
          sv_c = stateCOut;
          sv_d = stateDOut;
          if (dataVld) ovl_cnt++;
        end
      end
    end
  end

  // Send one message of k full words plus a final word of n bytes, then
  // compare the produced blocks with the padded reference.
  task automatic run_msg(input int k, input int n, input bit toggle, input bit stray,
                         input bit partial, input bit fix_last, input logic [31:0] fixed_word);
    logic [31:0] w [$];
    logic [7:0]  mb [$];
    logic [7:0]  pb [$];
    logic [31:0] ew [$];
    logic [63:0] blen;
    logic [31:0] x, lw;
    int          base, svb, i, cyc, nw, to, ng;
    bit          vld;

    for (int j = 0; j < k; j++) begin
      x = $urandom;
      w.push_back(x);
      for (int b = 0; b < 4; b++) mb.push_back(x[8*b +: 8]);
    end
    lw = fix_last ? fixed_word : $urandom;
    for (int b = 0; b < n; b++) mb.push_back(lw[8*b +: 8]);
    if (!partial) w.push_back(lw);
    nw = w.size();

    pb = mb;
    pb.push_back(8'h80);
    while ((pb.size() % 64) != 56) pb.push_back(8'h00);
    blen = 64'(mb.size()) * 64'd8;
    for (int b = 0; b < 8; b++) pb.push_back(blen[8*b +: 8]);
    for (int j = 0; j < pb.size() / 4; j++)
      ew.push_back({pb[4*j+3], pb[4*j+2], pb[4*j+1], pb[4*j]});

    base      = got_q.size();
    last_base = base;
    svb       = sv_cnt;
    stray_en  = stray;
    msg_id++;

    i   = 0;
    cyc = 0;
    while (i < nw && cyc < 3000) begin
      @(negedge clk);
      if (cyc == 1) check_val($sformatf("m%0d_stateVld_latency", msg_id), 64'(stateVld), 64'd1);
      if (cyc == 0) vld = 1'b1;
      else if (toggle) vld = ((cyc % 2) == 0);
      else vld = ($urandom_range(0, 3) != 0);
      msgVld  = vld;
      msgData = w[i];
      msgLast = (i == nw - 1) && !partial;
      msgBytes = (i == nw - 1 && !partial) ?
                 ((n == 4) ? 3'($urandom_range(4, 7)) : 3'(n)) : 3'($urandom_range(0, 7));
      if (vld && msgRdy) i++;
      cyc++;
    end
    @(posedge clk);
    #1;
    msgVld  = 1'b0;
    msgLast = 1'b0;
    check_val($sformatf("m%0d_words_sent", msg_id), 64'(i), 64'(nw));
    if (partial) return;

    to = 0;
    while (busy && to < 3000) begin
      @(negedge clk);
      to++;
    end
    check_val($sformatf("m%0d_done", msg_id), 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    ng = got_q.size() - base;
    check_val($sformatf("m%0d_word_count", msg_id), 64'(ng), 64'(ew.size()));
    for (int j = 0; j < ew.size() && j < ng; j++)
      check_val($sformatf("m%0d_w%0d", msg_id, j), 64'(got_q[base+j]), 64'(ew[j]));
    check_val($sformatf("m%0d_stateVld_count", msg_id), 64'(sv_cnt - svb), 64'd1);
    check_val($sformatf("m%0d_iv_a", msg_id), 64'(sv_a), 64'(iv_exp[0]));
    check_val($sformatf("m%0d_iv_b", msg_id), 64'(sv_b), 64'(iv_exp[1]));
    check_val($sformatf("m%0d_iv_c", msg_id), 64'(sv_c), 64'(iv_exp[2]));
    check_val($sformatf("m%0d_iv_d", msg_id), 64'(sv_d), 64'(iv_exp[3]));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_msgRdy"},   64'(msgRdy),    64'd0);
    check_val({tag, "_stateVld"}, 64'(stateVld),  64'd0);
    check_val({tag, "_stateA"},   64'(stateAOut), 64'd0);
    check_val({tag, "_stateB"},   64'(stateBOut), 64'd0);
    check_val({tag, "_stateC"},   64'(stateCOut), 64'd0);
    check_val({tag, "_stateD"},   64'(stateDOut), 64'd0);
    check_val({tag, "_dataVld"},  64'(dataVld),   64'd0);
    check_val({tag, "_dataOut"},  64'(dataOut),   64'd0);
    check_val({tag, "_busy"},     64'(busy),      64'd0);
  endtask

  initial begin
    int b2;
`ifdef MD5_FEED_EXT_IV_EN
    iv_a = $urandom;
    iv_b = $urandom;
    iv_c = $urandom;
    iv_d = $urandom;
    iv_exp[0] = iv_a;
    iv_exp[1] = iv_b;
    iv_exp[2] = iv_c;
    iv_exp[3] = iv_d;
`else
    iv_exp[0] = 32'h67452301;
    iv_exp[1] = 32'hEFCDAB89;
    iv_exp[2] = 32'h98BADCFE;
    iv_exp[3] = 32'h10325476;
`endif
    rst_n    = 1'b0;
    msgVld   = 1'b0;
    msgData  = 32'h0;
    msgLast  = 1'b0;
    msgBytes = 3'd0;

    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");

    // Empty message.
    run_msg(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("empty_w0",  64'(got_q[last_base]),    64'h00000080);
    check_val("empty_w14", 64'(got_q[last_base+14]), 64'h00000000);

    // "abc"; the unused top byte is zero as in the classic vector.
    run_msg(0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00636261);
    check_val("abc_w0",  64'(got_q[last_base]),    64'h80636261);
    check_val("abc_w14", 64'(got_q[last_base+14]), 64'h00000018);
    check_val("abc_w15", 64'(got_q[last_base+15]), 64'h00000000);

    // 56 bytes: length spills into a second block.
    run_msg(13, 4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("b56_b1w14", 64'(got_q[last_base+14]),    64'h00000080);
    check_val("b56_b2w14", 64'(got_q[last_base+16+14]), 64'h000001C0);

    // 64 bytes: a whole data block, then a pad/length block.
    run_msg(15, 4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("b64_b2w0",  64'(got_q[last_base+16]), 64'h00000080);
    check_val("b64_b2w14", 64'(got_q[last_base+30]), 64'h00000200);

    // Toggling msgVld plus stray digestVld during the block.
    run_msg(9, 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

    // Last word near the end of a block, every byte count.
    for (int kk = 12; kk <= 16; kk++)
      for (int nn = 0; nn <= 4; nn++)
        run_msg(kk, nn, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Random lengths and handshake patterns.
    for (int r = 0; r < 20; r++)
      run_msg($urandom_range(0, 40), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a block, after seven words.
    run_msg(7, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    b2 = got_q.size();
    repeat (10) @(negedge clk);
    check_val("no_dataVld_after_reset", 64'(got_q.size() - b2), 64'd0);
    run_msg(0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00636261);
    check_val("post_reset_abc_w0", 64'(got_q[last_base]), 64'h80636261);

    check_val("stateVld_dataVld_overlap", 64'(ovl_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
